sw_debounce_io: RTL and testbench

SW_DEBOUNCE_IO -- requirements
Module: sw_debounce_io

---
 rtl/sw_debounce_io.sv | 110 +++++++++++
 tb/tb_sw_debounce_io.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_io.sv
// Memory-mapped debouncer for ten board switches: 2-flop synchronizer, stability
// counter, DATA/CTRL register window and a level interrupt on accepted changes.
module sw_debounce_io #(
   parameter logic [15:0] BASE_ADDR = 16'hC000,
   parameter int          DB_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  SW,
   input  logic [15:0] addr,
   input  logic        re,
   input  logic        we,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic [9:0]  sw_stable,
   output logic        irq
);

   localparam logic [7:0]  CNT_MAX   = 8'(DB_CYCLES);
   localparam logic [7:0]  CNT_LAST  = 8'(DB_CYCLES - 1);
   localparam logic [15:0] DATA_ADDR = BASE_ADDR;
   localparam logic [15:0] CTRL_ADDR = BASE_ADDR + 16'd1;

   logic [9:0] s1_q, s1_d;
   logic [9:0] s2_q, s2_d;
   logic [9:0] cand_q, cand_d;
   logic [7:0] cnt_q, cnt_d;
   logic [9:0] stable_q, stable_d;
   logic       chg_q, chg_d;
   logic       ien_q, ien_d;
   logic       irq_q, irq_d;

   logic       data_rd;
   logic       ctrl_rd;
   logic       ctrl_wr;
   logic       busy;
   logic       accept;
   logic       unused_wdata;

   assign unused_wdata = ^wdata[15:2];

   assign data_rd = re && (addr == DATA_ADDR);
   assign ctrl_rd = re && (addr == CTRL_ADDR);
   assign ctrl_wr = we && (addr == CTRL_ADDR);

   assign busy   = (cand_q != stable_q) || (s2_q != cand_q);
   assign accept = (s2_q == cand_q) && (cnt_q == CNT_LAST) && (cand_q != stable_q);

   // Any movement of the synchronized value restarts the stability count.
   always_comb begin
      s1_d   = SW;
      s2_d   = s1_q;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = 8'd0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // A same-edge acceptance outranks both the read-clear and the W1C clear.
   always_comb begin
      stable_d = accept ? cand_q : stable_q;
      ien_d    = ctrl_wr ? wdata[1] : ien_q;
      chg_d    = chg_q;
      if (accept) begin
         chg_d = 1'b1;
      end else if (data_rd || (ctrl_wr && wdata[0])) begin
         chg_d = 1'b0;
      end
      irq_d = chg_q & ien_q;
   end

   always_comb begin
      rdata = 16'h0000;
      if (data_rd) begin
         rdata = {6'b0, stable_q};
      end else if (ctrl_rd) begin
         rdata = {13'b0, busy, ien_q, chg_q};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
         chg_q    <= 1'b0;
         ien_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         chg_q    <= chg_d;
         ien_q    <= ien_d;
         irq_q    <= irq_d;
      end
   end

   assign sw_stable = stable_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_sw_debounce_io.sv
// Bench for sw_debounce_io: scenario tasks plus a monitor that pops expected
// sw_stable values from a queue whenever the debounced output moves.
module tb_sw_debounce_io;

   localparam logic [15:0] BASE = 16'hC000;
   localparam logic [15:0] DATA_A = BASE;
   localparam logic [15:0] CTRL_A = BASE + 16'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  SW;
   logic [15:0] addr;
   logic        re;
   logic        we;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic [9:0]  sw_stable;
   logic        irq;

   int n_pass  = 0;
   int n_total = 0;
   logic [15:0] exp_q[$];
   logic [9:0]  prev_stable;

   sw_debounce_io #(.BASE_ADDR(BASE), .DB_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .SW(SW), .addr(addr), .re(re), .we(we),
      .wdata(wdata), .rdata(rdata), .sw_stable(sw_stable), .irq(irq)
   );

   always #5 clk = ~clk;

   // Scoreboard: every movement of sw_stable outside reset must match the queue head.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         prev_stable = sw_stable;
      end else if (sw_stable !== prev_stable) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: sw_stable=%h, no change expected", sw_stable);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({6'b0, sw_stable} !== e)
               $display("FAIL sb_value: sw_stable=%h expected %h", sw_stable, e);
            else
               n_pass++;
         end
         prev_stable = sw_stable;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
      addr = a;
      re   = 1'b1;
      #1 d = rdata;
      tick();
      re   = 1'b0;
      addr = 16'h0000;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
      addr  = 16'h0000;
      wdata = 16'h0000;
   endtask

   task automatic test_reset();
      rst = 1'b0; SW = 10'h2AA; addr = CTRL_A; re = 1'b0; we = 1'b0; wdata = 16'h0;
      #1 rst = 1'b1;
      #1;
      n_total++;
      if ({sw_stable, irq, rdata} !== 27'h0)
         $display("FAIL reset_outputs: sw_stable=%h irq=%b rdata=%h expected 0", sw_stable, irq, rdata);
      else n_pass++;
      ticks(3);
      n_total++;
      if ({sw_stable, irq} !== 11'h0)
         $display("FAIL reset_hold: sw_stable=%h irq=%b expected 0", sw_stable, irq);
      else n_pass++;
   endtask

   task automatic test_latency();
      logic [15:0] d;
      SW = 10'h155;
      exp_q.push_back(16'h0155);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6 || k == 7) begin
            n_total++;
            if (sw_stable !== ((k == 7) ? 10'h155 : 10'h000))
               $display("FAIL latency_edge%0d: sw_stable=%h", k, sw_stable);
            else n_pass++;
         end
      end
      bus_read(CTRL_A, d);
      n_total++;
      if (d !== 16'h0001) $display("FAIL latency_ctrl: got %h expected 0001", d);
      else n_pass++;
      bus_read(DATA_A, d);
      n_total++;
      if (d !== 16'h0155) $display("FAIL latency_data: got %h expected 0155", d);
      else n_pass++;
      bus_read(CTRL_A, d);
      n_total++;
      if (d !== 16'h0000) $display("FAIL latency_clr: got %h expected 0000", d);
      else n_pass++;
   endtask

   task automatic test_glitch();
      logic [15:0] d;
      SW = 10'h000;
      exp_q.push_back(16'h0000);
      ticks(10);
      bus_read(DATA_A, d);
      SW = 10'h001;
      ticks(2);
      addr = CTRL_A; re = 1'b1;
      #1;
      n_total++;
      if (rdata[2] !== 1'b1) $display("FAIL glitch_busy: busy=%b expected 1", rdata[2]);
      else n_pass++;
      tick();
      re = 1'b0; addr = 16'h0;
      SW = 10'h000;
      ticks(12);
      n_total++;
      if (sw_stable !== 10'h000) $display("FAIL glitch_stable: sw_stable=%h expected 000", sw_stable);
      else n_pass++;
      bus_read(CTRL_A, d);
      n_total++;
      if (d !== 16'h0000) $display("FAIL glitch_ctrl: got %h expected 0000", d);
      else n_pass++;
   endtask

   task automatic test_irq();
      logic [15:0] d;
      int budget;
      bus_write(CTRL_A, 16'h0002);
      bus_read(CTRL_A, d);
      n_total++;
      if (d !== 16'h0002 || irq !== 1'b0) $display("FAIL irq_ien: ctrl=%h irq=%b expected 0002/0", d, irq);
      else n_pass++;
      SW = 10'h3FF;
      exp_q.push_back(16'h03FF);
      budget = 0;
      while (sw_stable !== 10'h3FF && budget < 20) begin
         tick();
         budget++;
      end
      n_total++;
      if (sw_stable !== 10'h3FF || irq !== 1'b0)
         $display("FAIL irq_accept: sw_stable=%h irq=%b after %0d edges, expected 3ff/0", sw_stable, irq, budget);
      else n_pass++;
      tick();
      n_total++;
      if (irq !== 1'b1) $display("FAIL irq_rise: irq=%b expected 1", irq);
      else n_pass++;
      bus_read(DATA_A, d);
      n_total++;
      if (irq !== 1'b1) $display("FAIL irq_hold: irq=%b expected 1 on clear edge", irq);
      else n_pass++;
      tick();
      n_total++;
      if (irq !== 1'b0) $display("FAIL irq_fall: irq=%b expected 0", irq);
      else n_pass++;
      SW = 10'h0F0;
      exp_q.push_back(16'h00F0);
      ticks(9);
      n_total++;
      if (irq !== 1'b1) $display("FAIL irq_rise2: irq=%b expected 1", irq);
      else n_pass++;
      bus_write(CTRL_A, 16'h0000);
      tick();
      bus_read(CTRL_A, d);
      n_total++;
      if (irq !== 1'b0 || d !== 16'h0001) $display("FAIL irq_ien_off: irq=%b ctrl=%h expected 0/0001", irq, d);
      else n_pass++;
   endtask

   task automatic test_regs();
      logic [15:0] d;
      addr = CTRL_A; re = 1'b0;
      #1;
      n_total++;
      if (rdata !== 16'h0000) $display("FAIL regs_re_low: rdata=%h expected 0000", rdata);
      else n_pass++;
      bus_read(BASE + 16'd2, d);
      n_total++;
      if (d !== 16'h0000) $display("FAIL regs_unmapped_rd: got %h expected 0000", d);
      else n_pass++;
      bus_write(DATA_A, 16'h0003);
      bus_write(BASE - 16'd1, 16'h0003);
      bus_read(CTRL_A, d);
      n_total++;
      if (d !== 16'h0001) $display("FAIL regs_ignored_wr: ctrl=%h expected 0001", d);
      else n_pass++;
      // read and write in the same cycle: the write lands and W1C clears the flag
      addr = CTRL_A; re = 1'b1; we = 1'b1; wdata = 16'h0003;
      #1 d = rdata;
      tick();
      re = 1'b0; we = 1'b0; wdata = 16'h0;
      n_total++;
      if (d !== 16'h0001) $display("FAIL regs_rw_rdata: got %h expected 0001", d);
      else n_pass++;
      bus_read(CTRL_A, d);
      n_total++;
      if (d !== 16'h0002) $display("FAIL regs_rw_ctrl: got %h expected 0002", d);
      else n_pass++;
      bus_write(CTRL_A, 16'h0000);
   endtask

   task automatic test_read_on_accept();
      logic [15:0] d;
      SW = 10'h2C3;
      exp_q.push_back(16'h02C3);
      ticks(6);
      bus_read(DATA_A, d);
      n_total++;
      if (d !== 16'h00F0) $display("FAIL roa_data: got %h expected 00f0", d);
      else n_pass++;
      bus_read(CTRL_A, d);
      n_total++;
      if (sw_stable !== 10'h2C3 || d[0] !== 1'b1)
         $display("FAIL roa_flag: sw_stable=%h chg=%b expected 2c3/1", sw_stable, d[0]);
      else n_pass++;
      bus_read(DATA_A, d);
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      bus_write(CTRL_A, 16'h0002);
      SW = 10'h01E;
      ticks(2);
      rst = 1'b1;
      #1;
      n_total++;
      if ({sw_stable, irq, rdata} !== 27'h0)
         $display("FAIL rstmid_outputs: sw_stable=%h irq=%b rdata=%h expected 0", sw_stable, irq, rdata);
      else n_pass++;
      ticks(2);
      exp_q.push_back(16'h001E);
      rst = 1'b0;
      ticks(6);
      n_total++;
      if (sw_stable !== 10'h000) $display("FAIL rstmid_early: sw_stable=%h expected 000", sw_stable);
      else n_pass++;
      tick();
      n_total++;
      if (sw_stable !== 10'h01E) $display("FAIL rstmid_accept: sw_stable=%h expected 01e", sw_stable);
      else n_pass++;
      bus_read(CTRL_A, d);
      n_total++;
      if (d !== 16'h0001) $display("FAIL rstmid_ctrl: got %h expected 0001 (ien cleared by reset)", d);
      else n_pass++;
      bus_read(DATA_A, d);
   endtask

   task automatic test_random();
      logic [15:0] d;
      logic [9:0]  model;
      logic [9:0]  v;
      model = 10'h01E;
      for (int i = 0; i < 10; i++) begin
         v = (i == 5) ? model : 10'($urandom_range(0, 1023));
         if (v != model) exp_q.push_back({6'b0, v});
         SW = v;
         ticks(18);
         bus_read(CTRL_A, d);
         n_total++;
         if (d[0] !== (v != model)) $display("FAIL rand_flag%0d: chg=%b expected %b", i, d[0], (v != model));
         else n_pass++;
         bus_read(DATA_A, d);
         n_total++;
         if (d !== {6'b0, v} || sw_stable !== v)
            $display("FAIL rand_data%0d: rdata=%h sw_stable=%h expected %h", i, d, sw_stable, v);
         else n_pass++;
         model = v;
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_irq();
      test_regs();
      test_read_on_accept();
      test_reset_mid();
      test_random();
      ticks(2);
      n_total++;
      if (exp_q.size() != 0) $display("FAIL sb_drain: %0d expected changes never seen", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
